// File: rtl/axi4_master_bridge.sv
// -----------------------------------------------------------------------------
// axi4_master_bridge
//
// Turns the core's simple request / stream memory port into AXI4 master
// transactions. The bridge handles INCR bursts of 1-16 beats on 32-bit data
// and keeps only one transaction outstanding.
//
// Ports
//   ACLK, ARESETn                 clock, asynchronous active-low reset
//   req_valid/req_ready           request handshake (ready only when idle)
//   req_write, req_addr, req_len  burst direction, byte address, beats-1
//   wd_valid/wd_ready, wd_data,
//   wd_strb                       core write-data stream (in)
//   rd_valid/rd_ready, rd_data,
//   rd_last                       core read-data stream (out)
//   wr_done                       pulse when the write response is taken
//   rsp_err                       pulse on final rd beat / wr_done if error
//   AR*, R*, AW*, W*, B*          AXI4 master channels
// -----------------------------------------------------------------------------
module axi4_master_bridge #(
    parameter logic [3:0] ID_VAL = 4'h0
) (
    input  logic        ACLK,
    input  logic        ARESETn,
    // core request
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [3:0]  req_len,
    // core write-data stream
    input  logic        wd_valid,
    output logic        wd_ready,
    input  logic [31:0] wd_data,
    input  logic [3:0]  wd_strb,
    // core read-data stream
    output logic        rd_valid,
    input  logic        rd_ready,
    output logic [31:0] rd_data,
    output logic        rd_last,
    // status
    output logic        wr_done,
    output logic        rsp_err,
    // AXI AR
    output logic [3:0]  ARID,
    output logic [31:0] ARADDR,
    output logic [3:0]  ARLEN,
    output logic [2:0]  ARSIZE,
    output logic [1:0]  ARBURST,
    output logic        ARVALID,
    input  logic        ARREADY,
    // AXI R
    input  logic [3:0]  RID,
    input  logic [31:0] RDATA,
    input  logic [1:0]  RRESP,
    input  logic        RLAST,
    input  logic        RVALID,
    output logic        RREADY,
    // AXI AW
    output logic [3:0]  AWID,
    output logic [31:0] AWADDR,
    output logic [3:0]  AWLEN,
    output logic [2:0]  AWSIZE,
    output logic [1:0]  AWBURST,
    output logic        AWVALID,
    input  logic        AWREADY,
    // AXI W
    output logic [31:0] WDATA,
    output logic [3:0]  WSTRB,
    output logic        WLAST,
    output logic        WVALID,
    input  logic        WREADY,
    // AXI B
    input  logic [3:0]  BID,
    input  logic [1:0]  BRESP,
    input  logic        BVALID,
    output logic        BREADY
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RADDR,
        ST_RDATA,
        ST_WADDR,
        ST_WDATA,
        ST_WRESP
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] addr_q, addr_d;
    logic [3:0]  len_q, len_d;
    logic [3:0]  beat_cnt_q, beat_cnt_d;
    logic        err_acc_q, err_acc_d;

    // The low address bits are forced to zero on the bus; this keeps them
    // visibly consumed.
    logic unused_addr_bits;
    assign unused_addr_bits = ^req_addr[1:0];

    logic last_beat;
    logic r_hs;
    logic w_hs;
    logic b_hs;
    logic r_beat_err;
    logic b_err;

    assign last_beat  = (beat_cnt_q == len_q);
    assign r_hs       = (state_q == ST_RDATA) && RVALID && rd_ready;
    assign w_hs       = (state_q == ST_WDATA) && wd_valid && WREADY;
    assign b_hs       = (state_q == ST_WRESP) && BVALID;
    // A beat is bad on a non-OKAY response, a foreign ID, or RLAST that
    // disagrees with our own beat count.
    assign r_beat_err = (RRESP != 2'b00) | (RID != ID_VAL) | (RLAST != last_beat);
    assign b_err      = (BRESP != 2'b00) | (BID != ID_VAL);

    // Address channels: fields come straight from the latched request so they
    // stay constant while VALID waits for READY.
    assign req_ready = (state_q == ST_IDLE);
    assign ARVALID   = (state_q == ST_RADDR);
    assign ARID      = ID_VAL;
    assign ARADDR    = addr_q;
    assign ARLEN     = len_q;
    assign ARSIZE    = 3'b010;
    assign ARBURST   = 2'b01;
    assign AWVALID   = (state_q == ST_WADDR);
    assign AWID      = ID_VAL;
    assign AWADDR    = addr_q;
    assign AWLEN     = len_q;
    assign AWSIZE    = 3'b010;
    assign AWBURST   = 2'b01;

    // Data channels are pass-through, gated by state so nothing leaks while
    // another phase is active.
    assign rd_valid = (state_q == ST_RDATA) && RVALID;
    assign RREADY   = (state_q == ST_RDATA) && rd_ready;
    assign rd_data  = RDATA;
    assign rd_last  = (state_q == ST_RDATA) && last_beat;

    assign WVALID   = (state_q == ST_WDATA) && wd_valid;
    assign wd_ready = (state_q == ST_WDATA) && WREADY;
    assign WDATA    = wd_data;
    assign WSTRB    = wd_strb;
    assign WLAST    = (state_q == ST_WDATA) && last_beat;

    assign BREADY   = (state_q == ST_WRESP);
    assign wr_done  = b_hs;
    assign rsp_err  = (r_hs && last_beat && (err_acc_q | r_beat_err)) | (b_hs && b_err);

    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it
        // unassigned, which would otherwise infer a latch.
        state_d    = state_q;
        addr_d     = addr_q;
        len_d      = len_q;
        beat_cnt_d = beat_cnt_q;
        err_acc_d  = err_acc_q;

        unique case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    addr_d     = {req_addr[31:2], 2'b00};
                    len_d      = req_len;
                    beat_cnt_d = 4'd0;
                    err_acc_d  = 1'b0;
                    state_d    = req_write ? ST_WADDR : ST_RADDR;
                end
            end
            ST_RADDR: begin
                if (ARREADY) state_d = ST_RDATA;
            end
            ST_RDATA: begin
                if (r_hs) begin
                    err_acc_d = err_acc_q | r_beat_err;
                    // The count stops at len, so it can never wrap.
                    if (last_beat) state_d = ST_IDLE;
                    else           beat_cnt_d = beat_cnt_q + 4'd1;
                end
            end
            ST_WADDR: begin
                if (AWREADY) state_d = ST_WDATA;
            end
            ST_WDATA: begin
                if (w_hs) begin
                    if (last_beat) state_d = ST_WRESP;
                    else           beat_cnt_d = beat_cnt_q + 4'd1;
                end
            end
            ST_WRESP: begin
                if (BVALID) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value of its _d, independent of statement order.
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            state_q    <= ST_IDLE;
            addr_q     <= 32'd0;
            len_q      <= 4'd0;
            beat_cnt_q <= 4'd0;
            err_acc_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            len_q      <= len_d;
            beat_cnt_q <= beat_cnt_d;
            err_acc_q  <= err_acc_d;
        end
    end

endmodule

// File: doc/axi4_master_bridge.md
# axi4_master_bridge

Converts the core's simple request/stream memory interface into AXI4 master transactions, and is the initiator counterpart of the team's AXI4 SRAM slave wrapper. It handles INCR bursts of 1–16 beats on 32-bit data, one outstanding transaction at a time. It sits between the CPU's instruction/data memory ports and the AXI interconnect, with one instance per core port.

## Interface
- ID_VAL, default 4'h0: constant driven on ARID/AWID; returned RID/BID must match.
- ACLK  in  1  clock; all logic on rising edge.
- ARESETn  in  1  reset, asynchronous, active-low.
- req_valid  in  1  core request valid.
- req_ready  out  1  bridge can accept a request (state IDLE).
- req_write  in  1  1 = write burst, 0 = read burst.
- req_addr  in  32  byte address; [1:0] ignored, driven 2'b00 on AXI.
- req_len  in  4  beats minus one (0–15).
- wd_valid / wd_ready  in/out  1/1  core write-data stream handshake.
- wd_data, wd_strb  in  32, 4  write beat data and byte strobes.
- rd_valid / rd_ready  out/in  1/1  core read-data stream handshake.
- rd_data  out  32  read beat data.
- rd_last  out  1  final read beat.
- wr_done  out  1  one-cycle pulse when the write response is accepted.
- rsp_err  out  1  one-cycle pulse alongside the final rd beat or wr_done on error.
- AXI master AR: ARID 4, ARADDR 32, ARLEN 4, ARSIZE 3, ARBURST 2, ARVALID out; ARREADY in.
- AXI master R: RID 4, RDATA 32, RRESP 2, RLAST 1, RVALID in; RREADY out.
- AXI master AW: AWID 4, AWADDR 32, AWLEN 4, AWSIZE 3, AWBURST 2, AWVALID out; AWREADY in.
- AXI master W: WDATA 32, WSTRB 4, WLAST 1, WVALID out; WREADY in.
- AXI master B: BID 4, BRESP 2, BVALID in; BREADY out.

## Operation
- States: IDLE, RADDR, RDATA, WADDR, WDATA, WRESP.
- IDLE: req_ready=1. On req_valid, latch addr/len/write into registers, clear beat_cnt and err_acc, then go to WADDR (write) or RADDR (read).
- RADDR: ARVALID=1 with the registered address and length; ARSIZE=3'b010, ARBURST=2'b01. On ARVALID&&ARREADY, go to RDATA.
- RDATA: pure pass-through.
  - rd_valid=RVALID, RREADY=rd_ready, rd_data=RDATA.
  - rd_last = (beat_cnt==len).
  - On each R handshake, beat_cnt+1 and err_acc |= (RRESP!=0) | (RID!=ID_VAL) | (RLAST != (beat_cnt==len)).
  - On the handshake with beat_cnt==len: rsp_err = err_acc | the current beat's error, and go to IDLE.
- WADDR: AWVALID=1 with the same field rules as AR. On AWVALID&&AWREADY, go to WDATA. The bridge never asserts W before AW completes.
- WDATA: pass-through.
  - WVALID=wd_valid, wd_ready=WREADY, WDATA=wd_data, WSTRB=wd_strb.
  - WLAST = (beat_cnt==len).
  - On each W handshake, beat_cnt+1. On the handshake with WLAST=1, go to WRESP.
- WRESP: BREADY=1. On BVALID: wr_done=1 and rsp_err = (BRESP!=0) | (BID!=ID_VAL) for that cycle, then go to IDLE.
- Arithmetic: beat_cnt is 4 bits and never wraps, because the burst ends at len≤15.
- No 4 KB boundary split: the core guarantees requests stay within 4 KB.
- Pass-through signals are gated by state. Outside their state, RREADY, wd_ready, rd_valid, WVALID and BREADY are 0.

## Timing
- Reset (asynchronous): state=IDLE, all counters and registers cleared. Outputs during reset:
  - ARVALID, AWVALID, WVALID, RREADY, BREADY, wr_done, rsp_err, rd_valid, wd_ready = 0.
  - req_ready=1 once ARESETn deasserts.
  - ARADDR/AWADDR/ARLEN/AWLEN/WLAST = 0.
- ARVALID/AWVALID rise the cycle after request acceptance and hold stable with constant fields until the handshake. They never drop without a handshake.
- Minimum read latency: request accepted at cycle t, AR handshake at t+1, first R beat at t+2 at the earliest.
- Minimum write: request at t, AW at t+1, first W at t+2, BVALID accepted at t+3+len at the earliest. wr_done is in the same cycle as the B handshake.
- Back-to-back: req_ready rises in the cycle after the last R or B handshake.
- Stalls:
  - A read stall from either side (RVALID or rd_ready low) holds beat_cnt.
  - A wd_valid gap holds WVALID low and does not advance beat_cnt.
- Reset mid-burst aborts immediately. The slave is assumed to be reset by the same ARESETn.

## Test plan
- Single read: req addr 0x0000_0104, len 0; slave returns 0xDEADBEEF with RLAST. Required: ARADDR=0x104, ARLEN=0, rd_data=0xDEADBEEF with rd_last=1, rsp_err=0, req_ready again 1 cycle later.
- 4-beat read with rd_ready toggling 1,0,1,0… Required: exactly 4 RREADY handshakes, data order 0x10, 0x11, 0x12, 0x13, rd_last only on beat 4, no lost or duplicated beat.
- 8-beat write at 0x200, wd_strb 4'b0011, with wd_valid gaps and WREADY held low 3 cycles after AW. Required: AWLEN=7, WLAST only on beat 8, then wr_done pulse for 1 cycle with BREADY=1.
- Error paths. Required:
  - Read burst with RRESP=2'b10 on beat 2 of 3: rsp_err=1 on the final beat only.
  - Write with BID≠ID_VAL: rsp_err=1 with wr_done.
  - Read with RLAST on beat 1 of 2: rsp_err=1.
- ARREADY held low 10 cycles. Required: ARVALID, ARADDR and ARLEN stable throughout; req_ready=0.
- Reset asserted mid write burst (beat 3 of 8). Required: WVALID/AWVALID/BREADY drop to 0 immediately, state IDLE; a new read after reset completes normally.
